lc3_mem_access: RTL and testbench

Data-memory access unit for the LC3-2 pipeline. It sits between the controller's `mem_state` command and the data memory, and acts as the responder to that command. It performs direct reads, indirect (two-hop) reads and writes through a request/acknowledge memory port. It reports completion to the controller with a one-cycle `complete_data` pulse.

---
 rtl/lc3_pkg.sv | 14 +
 rtl/lc3_mem_access_if.sv | 25 ++
 rtl/lc3_mem_access.sv | 63 ++++++
 tb/tb_lc3_mem_access.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// lc3_pkg: command and access-FSM encodings shared by the LC3-2 controller and memory access unit
package lc3_pkg;
  typedef enum logic [2:0] {
    READ_MEM       = 3'd0,
    READ_MEM_INDIR = 3'd1,
    WRITE_MEM      = 3'd2,
    INIT_STATE     = 3'd3
  } mem_state_t;
  typedef enum logic [2:0] {IDLE, RD, IND1, WR, DONE, HOLD} acc_state_t;
  // codes 4-7 carry no command and behave like INIT_STATE
  function automatic mem_state_t decode_cmd(input logic [2:0] c);
    return (c > 3'd3) ? INIT_STATE : mem_state_t'(c);
  endfunction
endpackage

// File: rtl/lc3_mem_access_if.sv
// lc3_mem_access_if: controller command plus request/acknowledge data-memory port
interface lc3_mem_access_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [2:0]        mem_state;
  logic [ADDR_W-1:0] M_Addr;
  logic [DATA_W-1:0] M_Data;
  logic [DATA_W-1:0] Data_dout;
  logic              Data_ack;
  logic [ADDR_W-1:0] Data_addr;
  logic [DATA_W-1:0] Data_din;
  logic              Data_rd;
  logic              Data_req;
  logic [DATA_W-1:0] memout;
  logic              complete_data;
  modport slave (
    input  mem_state, M_Addr, M_Data, Data_dout, Data_ack,
    output Data_addr, Data_din, Data_rd, Data_req, memout, complete_data
  );
  modport master (
    output mem_state, M_Addr, M_Data, Data_dout, Data_ack,
    input  Data_addr, Data_din, Data_rd, Data_req, memout, complete_data
  );
endinterface

// File: rtl/lc3_mem_access.sv
// lc3_mem_access: direct, indirect and write data-memory accesses with a one-cycle completion pulse
module lc3_mem_access
  import lc3_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic clk,
  input  logic rst,
  lc3_mem_access_if.slave bus
);
  acc_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] memout_q, memout_d;
  mem_state_t        cmd;
  assign cmd = decode_cmd(bus.mem_state);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      memout_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      memout_q <= memout_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    memout_d = memout_q;
    case (state_q)
      IDLE: if (cmd != INIT_STATE) begin
        addr_d  = bus.M_Addr;
        data_d  = bus.M_Data;
        state_d = (cmd == READ_MEM) ? RD : (cmd == READ_MEM_INDIR) ? IND1 : WR;
      end
      IND1: if (bus.Data_ack) begin
        addr_d  = ADDR_W'(bus.Data_dout);
        state_d = RD;
      end
      RD: if (bus.Data_ack) begin
        memout_d = bus.Data_dout;
        state_d  = DONE;
      end
      WR:      state_d = bus.Data_ack ? DONE : WR;
      DONE:    state_d = HOLD;
      // a command held by the controller must not restart the access
      HOLD:    state_d = (cmd == INIT_STATE) ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  assign bus.Data_req      = state_q inside {RD, IND1, WR};
  assign bus.Data_rd       = state_q != WR;
  assign bus.Data_addr     = addr_q;
  assign bus.Data_din      = data_q;
  assign bus.memout        = memout_q;
  assign bus.complete_data = state_q == DONE;
endmodule

// File: tb/tb_lc3_mem_access.sv
// tb_lc3_mem_access: randomized accesses against a memory-array reference with wait-state injection
module tb_lc3_mem_access;
  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic [15:0] din;
  } req_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errs = 0;
  int   checks = 0;
  req_t log_q[$];
  int   waits_q[$];
  logic [15:0] mem [logic [15:0]];
  logic [15:0] exp_memout = 16'h0;
  int   w_left;
  logic busy = 1'b0;
  req_t cur;
  lc3_mem_access_if #(.ADDR_W(16), .DATA_W(16)) bus();
  lc3_mem_access #(.ADDR_W(16), .DATA_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] mem_get(input logic [15:0] a);
    if (!mem.exists(a)) mem[a] = 16'($urandom);
    return mem[a];
  endfunction
  // memory responder: per-request wait counts come from waits_q, completed requests go to log_q
  always @(negedge clk) begin
    if (!rst) begin
      bus.Data_ack = 1'b0;
      busy = 1'b0;
    end else if (bus.Data_req) begin
      if (!busy) begin
        busy   = 1'b1;
        w_left = (waits_q.size() > 0) ? waits_q.pop_front() : 0;
        cur    = '{bus.Data_rd, bus.Data_addr, bus.Data_din};
      end else begin
        check("stable_rd_addr", {15'h0, bus.Data_rd, bus.Data_addr}, {15'h0, cur.rd, cur.addr});
        check("stable_din", {16'h0, bus.Data_din}, {16'h0, cur.din});
      end
      if (w_left == 0) begin
        bus.Data_ack  = 1'b1;
        bus.Data_dout = cur.rd ? mem_get(cur.addr) : 16'($urandom);
        log_q.push_back(cur);
        if (!cur.rd) mem[cur.addr] = cur.din;
        busy = 1'b0;
      end else begin
        w_left--;
        bus.Data_ack  = 1'b0;
        bus.Data_dout = 16'($urandom);
      end
    end else begin
      busy = 1'b0;
      bus.Data_ack  = ($urandom_range(0, 3) == 0);
      bus.Data_dout = 16'($urandom);
    end
  end
  task automatic run_cmd(input logic [2:0] cmd, input logic [15:0] a, input logic [15:0] d,
                         input int w0, input int w1, input int hold, input logic [2:0] idle_code);
    req_t exp_q[$];
    logic [15:0] ptr;
    logic [15:0] new_out;
    int exp_t;
    int pulses;
    int pulse_t;
    int n;
    pulses  = 0;
    pulse_t = 0;
    log_q.delete();
    waits_q.delete();
    if (cmd == 3'd1) begin
      ptr = mem_get(a);
      exp_q.push_back('{1'b1, a, d});
      exp_q.push_back('{1'b1, ptr, d});
      waits_q.push_back(w0);
      waits_q.push_back(w1);
      new_out = mem_get(ptr);
      exp_t   = w0 + w1 + 3;
    end else begin
      exp_q.push_back('{cmd != 3'd2, a, d});
      waits_q.push_back(w0);
      new_out = (cmd == 3'd0) ? mem_get(a) : exp_memout;
      exp_t   = w0 + 2;
    end
    bus.mem_state = cmd;
    bus.M_Addr    = a;
    bus.M_Data    = d;
    n = ((exp_t > hold) ? exp_t : hold) + 2;
    for (int t = 1; t <= n; t++) begin
      @(negedge clk);
      if (t == 1) check("req_start", {31'h0, bus.Data_req}, 32'h1);
      if (bus.complete_data) begin
        pulses++;
        if (pulses == 1) begin
          pulse_t = t;
          check("memout_at_done", {16'h0, bus.memout}, {16'h0, new_out});
        end
      end
      if (t == 1) begin
        bus.M_Addr = 16'($urandom);
        bus.M_Data = 16'($urandom);
      end
      if (t == hold) bus.mem_state = idle_code;
    end
    exp_memout = new_out;
    check("done_pulses", pulses, 1);
    check("done_cycle", pulse_t, exp_t);
    check("memout_hold", {16'h0, bus.memout}, {16'h0, exp_memout});
    check("req_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check("req_rd_addr", {15'h0, log_q[i].rd, log_q[i].addr}, {15'h0, exp_q[i].rd, exp_q[i].addr});
      check("req_din", {16'h0, log_q[i].din}, {16'h0, exp_q[i].din});
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.mem_state = 3'd3;
    bus.M_Addr    = 16'h0;
    bus.M_Data    = 16'h0;
    bus.Data_ack  = 1'b0;
    bus.Data_dout = 16'h0;
    for (int i = 0; i < 8; i++) mem[16'h3000 + 16'(i)] = 16'h3000 + 16'((i * 3) % 8);
    repeat (2) @(negedge clk);
    check("rst_req", {31'h0, bus.Data_req}, 32'h0);
    check("rst_rd", {31'h0, bus.Data_rd}, 32'h1);
    check("rst_addr", {16'h0, bus.Data_addr}, 32'h0);
    check("rst_din", {16'h0, bus.Data_din}, 32'h0);
    check("rst_memout", {16'h0, bus.memout}, 32'h0);
    check("rst_done", {31'h0, bus.complete_data}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    mem[16'h3005] = 16'hBEEF;
    run_cmd(3'd0, 16'h3005, 16'h0000, 0, 0, 1, 3'd3);
    check("read_beef", {16'h0, bus.memout}, 32'hBEEF);
    run_cmd(3'd2, 16'h4000, 16'h1234, 2, 0, 1, 3'd3);
    mem[16'h3010] = 16'h3020;
    mem[16'h3020] = 16'h00AA;
    run_cmd(3'd1, 16'h3010, 16'h0000, 0, 0, 1, 3'd3);
    check("indir_aa", {16'h0, bus.memout}, 32'h00AA);
    run_cmd(3'd0, 16'h4000, 16'h0000, 0, 0, 10, 3'd3);
    check("readback_1234", {16'h0, bus.memout}, 32'h1234);
    log_q.delete();
    bus.mem_state = 3'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("undef_req", {31'h0, bus.Data_req}, 32'h0);
      check("undef_done", {31'h0, bus.complete_data}, 32'h0);
    end
    bus.mem_state = 3'd3;
    @(negedge clk);
    check("undef_log", log_q.size(), 0);
    log_q.delete();
    waits_q.delete();
    waits_q.push_back(50);
    bus.mem_state = 3'd1;
    bus.M_Addr    = 16'h3010;
    @(negedge clk);
    bus.mem_state = 3'd3;
    @(negedge clk);
    check("ind1_req", {31'h0, bus.Data_req}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_req", {31'h0, bus.Data_req}, 32'h0);
    check("mid_rst_rd", {31'h0, bus.Data_rd}, 32'h1);
    check("mid_rst_addr", {16'h0, bus.Data_addr}, 32'h0);
    check("mid_rst_din", {16'h0, bus.Data_din}, 32'h0);
    check("mid_rst_memout", {16'h0, bus.memout}, 32'h0);
    check("mid_rst_done", {31'h0, bus.complete_data}, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_nodone", {31'h0, bus.complete_data}, 32'h0);
    end
    rst = 1'b1;
    exp_memout = 16'h0;
    waits_q.delete();
    check("mid_rst_log", log_q.size(), 0);
    @(negedge clk);
    run_cmd(3'd0, 16'h3020, 16'h0000, 1, 0, 1, 3'd3);
    check("post_rst_read", {16'h0, bus.memout}, 32'h00AA);
    for (int k = 0; k < 40; k++) begin
      run_cmd(3'($urandom_range(0, 2)), 16'h3000 + 16'($urandom_range(0, 7)), 16'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 8),
              3'd3 + 3'($urandom_range(0, 4)));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
